// File: rtl/debug_exec_ctrl.sv
// Purpose: debug sequencer that loads the instruction memory from UART bytes and runs or steps the CPU with dumps.
// Latency: every output is registered, so a byte or event sampled at one edge shows its effect right after that edge.
// Backpressure: none on the rx side (unwanted bytes are dropped); the DUMP state waits for i_tx_done.
module debug_exec_ctrl #(
    parameter int N_BITS       = 8,
    parameter int N_BITS_INSTR = 32,
    parameter int IMEM_ADDR_W  = 11
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [N_BITS-1:0]       i_rx_data,
    input  logic                    i_rx_done,
    input  logic                    i_cpu_halt,
    input  logic                    i_tx_done,
    output logic                    o_imem_we,
    output logic [IMEM_ADDR_W-1:0]  o_imem_addr,
    output logic [N_BITS_INSTR-1:0] o_imem_data,
    output logic                    o_cpu_en,
    output logic                    o_cpu_reset,
    output logic                    o_dump_start,
    output logic [IMEM_ADDR_W:0]    o_prog_len,
    output logic                    o_load_err,
    output logic [2:0]              o_state
);

    localparam int BYTES = N_BITS_INSTR / N_BITS;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

    localparam logic [N_BITS-1:0] CMD_LOAD  = N_BITS'(8'h4C);
    localparam logic [N_BITS-1:0] CMD_CONT  = N_BITS'(8'h43);
    localparam logic [N_BITS-1:0] CMD_STEP  = N_BITS'(8'h53);
    localparam logic [N_BITS-1:0] CMD_NEXT  = N_BITS'(8'h4E);
    localparam logic [N_BITS-1:0] CMD_ABORT = N_BITS'(8'h41);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_RUN_CONT  = 3'd2,
        S_STEP_WAIT = 3'd3,
        S_STEP_EXEC = 3'd4,
        S_DUMP      = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [BC_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [N_BITS_INSTR-1:0] asm_q, asm_d;
    logic [IMEM_ADDR_W:0]    prog_len_q, prog_len_d;
    logic                    load_err_q, load_err_d;
    logic                    load_done_q, load_done_d;
    logic                    halt_seen_q, halt_seen_d;
    logic                    dump_from_step_q, dump_from_step_d;
    logic                    imem_we_q, imem_we_d;
    logic [IMEM_ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [N_BITS_INSTR-1:0] imem_data_q, imem_data_d;
    logic                    cpu_en_q, cpu_en_d;
    logic                    cpu_reset_q, cpu_reset_d;
    logic                    dump_start_q, dump_start_d;
    logic [N_BITS_INSTR-1:0] new_word;

    // Next-state and registered-output decode for the command sequencer.
    always_comb begin
        state_d          = state_q;
        byte_cnt_d       = byte_cnt_q;
        asm_d            = asm_q;
        prog_len_d       = prog_len_q;
        load_err_d       = load_err_q;
        load_done_d      = 1'b0;
        halt_seen_d      = halt_seen_q;
        dump_from_step_d = dump_from_step_q;
        imem_we_d        = 1'b0;
        imem_addr_d      = imem_addr_q;
        imem_data_d      = imem_data_q;
        cpu_en_d         = 1'b0;
        cpu_reset_d      = 1'b0;
        dump_start_d     = 1'b0;
        // Little-endian assembly: byte k lands in lane k of the word.
        new_word = asm_q;
        new_word[byte_cnt_q*N_BITS +: N_BITS] = i_rx_data;

        case (state_q)
            S_IDLE: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_d     = S_LOAD;
                        cpu_reset_d = 1'b1;
                        prog_len_d  = '0;
                        load_err_d  = 1'b0;
                        byte_cnt_d  = '0;
                        asm_d       = '0;
                    end else if (i_rx_data == CMD_CONT && prog_len_q != '0) begin
                        state_d     = S_RUN_CONT;
                        cpu_reset_d = 1'b1;
                        halt_seen_d = 1'b0;
                    end else if (i_rx_data == CMD_STEP && prog_len_q != '0) begin
                        state_d     = S_STEP_WAIT;
                        cpu_reset_d = 1'b1;
                        halt_seen_d = 1'b0;
                    end
                end
            end

            S_LOAD: begin
                // The final write is shown while still in LOAD; leave one cycle later.
                if (load_done_q) begin
                    state_d = S_IDLE;
                end else if (i_rx_done) begin
                    asm_d = new_word;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d  = '0;
                        imem_we_d   = 1'b1;
                        imem_addr_d = prog_len_q[IMEM_ADDR_W-1:0];
                        imem_data_d = new_word;
                        prog_len_d  = prog_len_q + 1'b1;
                        if (new_word == '1) begin
                            load_done_d = 1'b1;
                        end else if (prog_len_q[IMEM_ADDR_W-1:0] == '1) begin
                            load_err_d  = 1'b1;
                            load_done_d = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end

            S_RUN_CONT: begin
                // During the CPU reset pulse the halt level may still belong to the previous run.
                if (i_cpu_halt && !cpu_reset_q) begin
                    state_d          = S_DUMP;
                    halt_seen_d      = 1'b1;
                    dump_start_d     = 1'b1;
                    dump_from_step_d = 1'b0;
                end else begin
                    cpu_en_d = 1'b1;
                end
            end

            S_STEP_WAIT: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_ABORT) begin
                        state_d = S_IDLE;
                    end else if (i_rx_data == CMD_NEXT && !halt_seen_q) begin
                        state_d  = S_STEP_EXEC;
                        cpu_en_d = 1'b1;
                    end
                end
            end

            S_STEP_EXEC: begin
                state_d          = S_DUMP;
                dump_start_d     = 1'b1;
                dump_from_step_d = 1'b1;
                if (i_cpu_halt) halt_seen_d = 1'b1;
            end

            S_DUMP: begin
                if (i_cpu_halt) halt_seen_d = 1'b1;
                if (i_tx_done) state_d = dump_from_step_q ? S_STEP_WAIT : S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q          <= S_IDLE;
            byte_cnt_q       <= '0;
            asm_q            <= '0;
            prog_len_q       <= '0;
            load_err_q       <= 1'b0;
            load_done_q      <= 1'b0;
            halt_seen_q      <= 1'b0;
            dump_from_step_q <= 1'b0;
            imem_we_q        <= 1'b0;
            imem_addr_q      <= '0;
            imem_data_q      <= '0;
            cpu_en_q         <= 1'b0;
            cpu_reset_q      <= 1'b0;
            dump_start_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            byte_cnt_q       <= byte_cnt_d;
            asm_q            <= asm_d;
            prog_len_q       <= prog_len_d;
            load_err_q       <= load_err_d;
            load_done_q      <= load_done_d;
            halt_seen_q      <= halt_seen_d;
            dump_from_step_q <= dump_from_step_d;
            imem_we_q        <= imem_we_d;
            imem_addr_q      <= imem_addr_d;
            imem_data_q      <= imem_data_d;
            cpu_en_q         <= cpu_en_d;
            cpu_reset_q      <= cpu_reset_d;
            dump_start_q     <= dump_start_d;
        end
    end

    assign o_imem_we    = imem_we_q;
    assign o_imem_addr  = imem_addr_q;
    assign o_imem_data  = imem_data_q;
    assign o_cpu_en     = cpu_en_q;
    assign o_cpu_reset  = cpu_reset_q;
    assign o_dump_start = dump_start_q;
    assign o_prog_len   = prog_len_q;
    assign o_load_err   = load_err_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_debug_exec_ctrl.sv
module tb_debug_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;
    logic        cpu_halt = 1'b0;
    logic        tx_done = 1'b0;

    logic        imem_we, cpu_en, cpu_reset, dump_start, load_err;
    logic [10:0] imem_addr;
    logic [31:0] imem_data;
    logic [11:0] prog_len;
    logic [2:0]  state;

    // Small instance (4-word memory) for the overflow case.
    logic [7:0]  s_rx_data = '0;
    logic        s_rx_done = 1'b0;
    logic        s_imem_we, s_cpu_en, s_cpu_reset, s_dump_start, s_load_err;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_data;
    logic [2:0]  s_prog_len;
    logic [2:0]  s_state;

    int vectors = 0;
    int errors  = 0;
    int en_cnt  = 0;
    int ds_cnt  = 0;
    int we_cnt  = 0;

    debug_exec_ctrl dut (
        .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_cpu_halt(cpu_halt), .i_tx_done(tx_done),
        .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_data(imem_data),
        .o_cpu_en(cpu_en), .o_cpu_reset(cpu_reset), .o_dump_start(dump_start),
        .o_prog_len(prog_len), .o_load_err(load_err), .o_state(state)
    );

    debug_exec_ctrl #(.N_BITS(8), .N_BITS_INSTR(32), .IMEM_ADDR_W(2)) dut_s (
        .i_clk(clk), .i_reset(rst), .i_rx_data(s_rx_data), .i_rx_done(s_rx_done),
        .i_cpu_halt(1'b0), .i_tx_done(1'b0),
        .o_imem_we(s_imem_we), .o_imem_addr(s_imem_addr), .o_imem_data(s_imem_data),
        .o_cpu_en(s_cpu_en), .o_cpu_reset(s_cpu_reset), .o_dump_start(s_dump_start),
        .o_prog_len(s_prog_len), .o_load_err(s_load_err), .o_state(s_state)
    );

    always #5 clk = ~clk;

    // Pulse counters plus two invariants checked every cycle.
    always @(negedge clk) begin
        if (cpu_en === 1'b1) en_cnt++;
        if (dump_start === 1'b1) ds_cnt++;
        if (imem_we === 1'b1) we_cnt++;
        vectors++;
        if ((cpu_reset === 1'b1 && cpu_en === 1'b1) || (imem_we === 1'b1 && state !== 3'd1)) begin
            errors++;
            $display("FAIL invariant got en=%0b rst=%0b we=%0b state=%0d", cpu_en, cpu_reset, imem_we, state);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic send_byte_s(input logic [7:0] b);
        s_rx_data = b;
        s_rx_done = 1'b1;
        tick();
        s_rx_done = 1'b0;
    endtask

    task automatic send_word_s(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte_s(w[8*k +: 8]);
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({imem_we, imem_addr, imem_data, cpu_en, cpu_reset, dump_start, prog_len, load_err, state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got we=%0b en=%0b rst=%0b ds=%0b len=%0d err=%0b st=%0d exp all 0",
                     imem_we, cpu_en, cpu_reset, dump_start, prog_len, load_err, state);
        end
        vectors++;
        if ({s_imem_we, s_cpu_en, s_cpu_reset, s_dump_start, s_prog_len, s_load_err, s_state} !== '0) begin
            errors++;
            $display("FAIL reset_small got len=%0d err=%0b st=%0d exp 0", s_prog_len, s_load_err, s_state);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ignored();
        send_byte(8'h43);
        vectors++;
        if (state !== 3'd0 || cpu_reset !== 1'b0) begin
            errors++; $display("FAIL cont_no_prog got st=%0d rst=%0b exp 0/0", state, cpu_reset);
        end
        send_byte(8'h99);
        send_byte(8'h53);
        send_byte(8'h4E);
        vectors++;
        if (state !== 3'd0 || cpu_reset !== 1'b0 || cpu_en !== 1'b0 || prog_len !== 12'd0) begin
            errors++; $display("FAIL idle_junk got st=%0d rst=%0b en=%0b len=%0d exp 0", state, cpu_reset, cpu_en, prog_len);
        end
    endtask

    task automatic test_load();
        int we0;
        we0 = we_cnt;
        send_byte(8'h4C);
        vectors++;
        if (state !== 3'd1 || cpu_reset !== 1'b1) begin
            errors++; $display("FAIL load_enter got st=%0d rst=%0b exp 1/1", state, cpu_reset);
        end
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h08);
        vectors++;
        if (imem_we !== 1'b0) begin
            errors++; $display("FAIL partial_no_write got %0b exp 0", imem_we);
        end
        send_byte(8'h20);
        vectors++;
        if (imem_we !== 1'b1 || imem_addr !== 11'd0 || imem_data !== 32'h20080013 || prog_len !== 12'd1) begin
            errors++; $display("FAIL word0 got we=%0b a=%0d d=%h len=%0d exp 1/0/20080013/1", imem_we, imem_addr, imem_data, prog_len);
        end
        tick();
        vectors++;
        if (imem_we !== 1'b0 || state !== 3'd1) begin
            errors++; $display("FAIL word0_pulse got we=%0b st=%0d exp 0/1", imem_we, state);
        end
        for (int k = 0; k < 4; k++) send_byte(8'hFF);
        vectors++;
        if (imem_we !== 1'b1 || imem_addr !== 11'd1 || imem_data !== 32'hFFFFFFFF || prog_len !== 12'd2) begin
            errors++; $display("FAIL word1 got we=%0b a=%0d d=%h len=%0d exp 1/1/ffffffff/2", imem_we, imem_addr, imem_data, prog_len);
        end
        tick();
        vectors++;
        if (state !== 3'd0 || imem_we !== 1'b0 || load_err !== 1'b0 || prog_len !== 12'd2) begin
            errors++; $display("FAIL load_done got st=%0d we=%0b err=%0b len=%0d exp 0/0/0/2", state, imem_we, load_err, prog_len);
        end
        vectors++;
        if (we_cnt - we0 !== 2) begin
            errors++; $display("FAIL load_we_count got %0d exp 2", we_cnt - we0);
        end
    endtask

    task automatic test_cont();
        int en0, ds0;
        en0 = en_cnt; ds0 = ds_cnt;
        send_byte(8'h43);
        vectors++;
        if (state !== 3'd2 || cpu_reset !== 1'b1 || cpu_en !== 1'b0) begin
            errors++; $display("FAIL cont_enter got st=%0d rst=%0b en=%0b exp 2/1/0", state, cpu_reset, cpu_en);
        end
        send_byte(8'h41);
        for (int i = 0; i < 9; i++) tick();
        vectors++;
        if (cpu_en !== 1'b1 || state !== 3'd2) begin
            errors++; $display("FAIL cont_running got en=%0b st=%0d exp 1/2", cpu_en, state);
        end
        cpu_halt = 1'b1;
        rx_data = 8'h4C; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        vectors++;
        if (cpu_en !== 1'b0 || state !== 3'd5 || dump_start !== 1'b1) begin
            errors++; $display("FAIL cont_halt got en=%0b st=%0d ds=%0b exp 0/5/1", cpu_en, state, dump_start);
        end
        tick();
        vectors++;
        if (dump_start !== 1'b0 || state !== 3'd5) begin
            errors++; $display("FAIL cont_dump_wait got ds=%0b st=%0d exp 0/5", dump_start, state);
        end
        pulse_tx_done();
        cpu_halt = 1'b0;
        vectors++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL cont_return got st=%0d exp 0", state);
        end
        vectors++;
        if (en_cnt - en0 < 10 || ds_cnt - ds0 !== 1) begin
            errors++; $display("FAIL cont_counts got en=%0d ds=%0d exp >=10/1", en_cnt - en0, ds_cnt - ds0);
        end
    endtask

    task automatic test_step();
        int en0, ds0;
        send_byte(8'h53);
        vectors++;
        if (state !== 3'd3 || cpu_reset !== 1'b1 || cpu_en !== 1'b0) begin
            errors++; $display("FAIL step_enter got st=%0d rst=%0b en=%0b exp 3/1/0", state, cpu_reset, cpu_en);
        end
        tick();
        en0 = en_cnt; ds0 = ds_cnt;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h4E);
            vectors++;
            if (state !== 3'd4 || cpu_en !== 1'b1) begin
                errors++; $display("FAIL step_exec got st=%0d en=%0b exp 4/1", state, cpu_en);
            end
            if (i == 1) begin
                // tx_done outside DUMP is ignored; held on, it completes with the dump_start cycle.
                tx_done = 1'b1;
                tick();
                vectors++;
                if (state !== 3'd5 || dump_start !== 1'b1) begin
                    errors++; $display("FAIL step_txdone_early got st=%0d ds=%0b exp 5/1", state, dump_start);
                end
                tick();
                tx_done = 1'b0;
            end else begin
                tick();
                vectors++;
                if (state !== 3'd5 || cpu_en !== 1'b0 || dump_start !== 1'b1) begin
                    errors++; $display("FAIL step_dump got st=%0d en=%0b ds=%0b exp 5/0/1", state, cpu_en, dump_start);
                end
                send_byte(8'h41);
                pulse_tx_done();
            end
            vectors++;
            if (state !== 3'd3) begin
                errors++; $display("FAIL step_back got st=%0d exp 3", state);
            end
        end
        tick();
        vectors++;
        if (en_cnt - en0 !== 3 || ds_cnt - ds0 !== 3) begin
            errors++; $display("FAIL step_counts got en=%0d ds=%0d exp 3/3", en_cnt - en0, ds_cnt - ds0);
        end
        send_byte(8'h41);
        vectors++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL step_abort got st=%0d exp 0", state);
        end
    endtask

    task automatic test_step_halt();
        int en0;
        send_byte(8'h53);
        send_byte(8'h4E);
        tick();
        pulse_tx_done();
        send_byte(8'h4E);
        cpu_halt = 1'b1;
        tick();
        tick();
        cpu_halt = 1'b0;
        pulse_tx_done();
        vectors++;
        if (state !== 3'd3) begin
            errors++; $display("FAIL halt_step_back got st=%0d exp 3", state);
        end
        en0 = en_cnt;
        send_byte(8'h4E);
        tick(); tick();
        vectors++;
        if (state !== 3'd3 || en_cnt - en0 !== 0) begin
            errors++; $display("FAIL halt_next_ignored got st=%0d en_pulses=%0d exp 3/0", state, en_cnt - en0);
        end
        send_byte(8'h41);
        vectors++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL halt_abort got st=%0d exp 0", state);
        end
    endtask

    task automatic test_reset_mid_load();
        send_byte(8'h4C);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({imem_we, imem_addr, imem_data, cpu_en, cpu_reset, dump_start, prog_len, load_err, state} !== '0) begin
            errors++; $display("FAIL midload_reset got st=%0d len=%0d d=%h exp all 0", state, prog_len, imem_data);
        end
        send_byte(8'h4C);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        vectors++;
        if (imem_we !== 1'b1 || imem_addr !== 11'd0 || imem_data !== 32'h44332211 || prog_len !== 12'd1) begin
            errors++; $display("FAIL reload_word got we=%0b a=%0d d=%h len=%0d exp 1/0/44332211/1", imem_we, imem_addr, imem_data, prog_len);
        end
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_byte(8'h4C);
        for (int k = 0; k < 4; k++) send_byte(8'hFF);
        tick();
        send_byte(8'h43);
        tick(); tick();
        vectors++;
        if (cpu_en !== 1'b1) begin
            errors++; $display("FAIL run_before_reset got en=%0b exp 1", cpu_en);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (cpu_en !== 1'b0 || state !== 3'd0 || prog_len !== 12'd0) begin
            errors++; $display("FAIL run_reset got en=%0b st=%0d len=%0d exp 0/0/0", cpu_en, state, prog_len);
        end
    endtask

    task automatic test_load_overflow();
        send_byte_s(8'h4C);
        for (int w = 0; w < 3; w++) send_word_s(32'h01000000 + w);
        vectors++;
        if (s_load_err !== 1'b0 || s_prog_len !== 3'd3 || s_imem_addr !== 2'd2) begin
            errors++; $display("FAIL small_3words got err=%0b len=%0d a=%0d exp 0/3/2", s_load_err, s_prog_len, s_imem_addr);
        end
        send_word_s(32'h01000003);
        vectors++;
        if (s_imem_we !== 1'b1 || s_imem_addr !== 2'd3 || s_imem_data !== 32'h01000003 || s_load_err !== 1'b1 || s_prog_len !== 3'd4) begin
            errors++; $display("FAIL small_overflow got we=%0b a=%0d d=%h err=%0b len=%0d exp 1/3/01000003/1/4",
                               s_imem_we, s_imem_addr, s_imem_data, s_load_err, s_prog_len);
        end
        tick();
        vectors++;
        if (s_state !== 3'd0 || s_load_err !== 1'b1) begin
            errors++; $display("FAIL small_idle got st=%0d err=%0b exp 0/1", s_state, s_load_err);
        end
    endtask

    initial begin
        test_reset();
        test_ignored();
        test_load();
        test_cont();
        test_step();
        test_step_halt();
        test_reset_mid_load();
        test_reset_mid_run();
        test_load_overflow();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/debug_exec_ctrl.md
Name: debug_exec_ctrl

Overview:
Debug-unit sequencer between the UART receiver and the pipelined processor. Decodes command bytes from the host and loads the program into instruction memory as little-endian 32-bit words. Runs the CPU either continuously or step by step, and triggers a register/memory dump through the TX side after each step and at halt. All outputs are registered.

Parameters:
N_BITS, 8, UART byte width
N_BITS_INSTR, 32, instruction width (4 bytes)
IMEM_ADDR_W, 11, instruction memory word-address width (2048 words)

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, synchronous, active-high
i_rx_data  in  N_BITS  received byte, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse per received byte
i_cpu_halt  in  1  CPU has retired the HALT instruction (level)
i_tx_done  in  1  one-cycle pulse: dump transmission finished
o_imem_we  out  1  instruction memory write strobe (1 cycle)
o_imem_addr  out  IMEM_ADDR_W  write word address
o_imem_data  out  N_BITS_INSTR  write data
o_cpu_en  out  1  pipeline clock-enable
o_cpu_reset  out  1  one-cycle CPU/PC reset pulse
o_dump_start  out  1  one-cycle request to TX dump unit
o_prog_len  out  IMEM_ADDR_W+1  words loaded, including HALT
o_load_err  out  1  sticky: memory filled without HALT
o_state  out  3  current state encoding (debug/LEDs)

Behaviour:
- Reset: state IDLE (0). All outputs 0, including o_prog_len and o_load_err. The byte counter, word counter, assembly register and halt_seen are cleared. Reset mid-load discards the partial word. Reset mid-run drops o_cpu_en on the next edge.
- States: IDLE=0, LOAD=1, RUN_CONT=2, STEP_WAIT=3, STEP_EXEC=4, DUMP=5.
- Byte handling: a byte is consumed only on i_rx_done=1. Response is registered: the pulse at edge t produces the state/outputs at t+1.
- IDLE, byte-to-action:
  - 0x4C 'L': go to LOAD, pulse o_cpu_reset, clear o_prog_len, o_load_err and the counters.
  - 0x43 'C': go to RUN_CONT, pulse o_cpu_reset, clear halt_seen.
  - 0x53 'S': go to STEP_WAIT, pulse o_cpu_reset, clear halt_seen.
  - 'C' and 'S' are ignored when o_prog_len==0.
  - Any other byte is ignored.
- LOAD:
  - Byte k (k=0..3) fills word bits [8k+7:8k].
  - On the 4th byte, the next cycle shows o_imem_we=1 with o_imem_addr = word count and o_imem_data = the assembled word. The word count then increments and o_prog_len = new count.
  - Word == all ones (HALT): it is written, then the block returns to IDLE.
  - Write at address 2^IMEM_ADDR_W-1 that is not HALT: o_load_err=1, return to IDLE.
  - Partial-word bytes never produce a write.
- RUN_CONT:
  - o_cpu_en=1 every cycle.
  - When i_cpu_halt=1 is sampled, the next cycle has o_cpu_en=0, halt_seen=1, state DUMP.
  - Rx bytes are ignored.
- STEP_WAIT:
  - o_cpu_en=0.
  - Byte 0x4E 'N': go to STEP_EXEC.
  - Byte 0x41 'A': go to IDLE.
  - Other bytes are ignored.
  - If halt_seen=1 on entry, 'N' is ignored (only 'A' is accepted).
- STEP_EXEC: o_cpu_en=1 for exactly one cycle, then DUMP.
- halt_seen: set whenever i_cpu_halt=1 is sampled in RUN_CONT, STEP_EXEC or DUMP.
- DUMP:
  - o_dump_start=1 for the first cycle in DUMP only.
  - Wait for i_tx_done; rx bytes are ignored.
  - On i_tx_done: came from RUN_CONT → IDLE; came from a step → STEP_WAIT.
  - i_tx_done in the same cycle as o_dump_start counts as done.
- Simultaneous events:
  - i_rx_done and i_cpu_halt in RUN_CONT: halt wins, the byte is dropped.
  - i_tx_done outside DUMP: ignored.
- o_cpu_reset is never asserted together with o_cpu_en.
- o_imem_we is only ever asserted in LOAD.

Test Plan:
- Reset, then 'L' followed by bytes 13 00 08 20 FF FF FF FF → writes addr0=0x20080013 and addr1=0xFFFFFFFF. Each o_imem_we is 1 cycle; o_prog_len=2; back in IDLE; o_load_err=0.
- Load as above, then 'C', hold i_cpu_halt=0 for 10 cycles, then 1 → o_cpu_reset pulse, o_cpu_en high 10+ cycles, then low the cycle after halt. o_dump_start pulses once; after i_tx_done the state is IDLE.
- Load, then 'S', then 'N' three times with i_tx_done returned each time → exactly 3 single-cycle o_cpu_en pulses and 3 o_dump_start pulses; state STEP_WAIT; then 'A' → IDLE.
- Step mode with i_cpu_halt=1 during the 2nd step → after the dump the state is STEP_WAIT. A further 'N' gives no o_cpu_en; 'A' → IDLE.
- 'C' with o_prog_len=0, and byte 0x99 in IDLE → no outputs change, state stays IDLE.
- i_reset asserted after 2 bytes of a word in LOAD → all outputs 0. A new 'L' plus 4 bytes writes addr0 with only the new bytes. Also, with IMEM_ADDR_W=2, 4 non-HALT words → o_load_err=1, o_prog_len=4.
